// File: rtl/swervolf_axi_pkg.sv
// Shared gate definitions: operating modes, error-responder states and the SLVERR code.
package swervolf_axi_pkg;

  typedef enum logic [1:0] {
    MODE_WAIT = 2'd0,
    MODE_PASS = 2'd1,
    MODE_ERR  = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_err_slave.sv
// Local AXI slave that terminates every write and read with SLVERR, one outstanding per direction.
// B asserts the cycle after the wlast handshake, first R the cycle after AR; responses hold until ready.
module axi_err_slave
  import swervolf_axi_pkg::*;
#(
  parameter int ID_WIDTH   = 6,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic [ID_WIDTH-1:0]   aw_id,
  input  logic                  aw_valid,
  output logic                  aw_ready,
  input  logic                  w_last,
  input  logic                  w_valid,
  output logic                  w_ready,
  output logic [ID_WIDTH-1:0]   b_id,
  output logic [1:0]            b_resp,
  output logic                  b_valid,
  input  logic                  b_ready,
  input  logic [ID_WIDTH-1:0]   ar_id,
  input  logic [7:0]            ar_len,
  input  logic                  ar_valid,
  output logic                  ar_ready,
  output logic [ID_WIDTH-1:0]   r_id,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [1:0]            r_resp,
  output logic                  r_last,
  output logic                  r_valid,
  input  logic                  r_ready
);

  wr_state_t w_state, w_next;
  rd_state_t r_state, r_next;
  logic [ID_WIDTH-1:0] bid_q, rid_q;
  logic [7:0]          beat_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next   = w_state;
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b0;
    b_resp   = RESP_OKAY;
    case (w_state)
      W_IDLE: begin
        aw_ready = en;
        if (en && aw_valid) w_next = W_DATA;
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (w_valid && w_last) w_next = W_RESP;
      end
      W_RESP: begin
        b_valid = 1'b1;
        b_resp  = RESP_SLVERR;
        if (b_ready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // beat_cnt holds the number of beats still to send after the current one
  always_comb begin
    r_next   = r_state;
    ar_ready = 1'b0;
    r_valid  = 1'b0;
    r_resp   = RESP_OKAY;
    r_last   = 1'b0;
    case (r_state)
      R_IDLE: begin
        ar_ready = en;
        if (en && ar_valid) r_next = R_DATA;
      end
      R_DATA: begin
        r_valid = 1'b1;
        r_resp  = RESP_SLVERR;
        r_last  = (beat_cnt == 8'd0);
        if (r_ready && beat_cnt == 8'd0) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bid_q    <= '0;
      rid_q    <= '0;
      beat_cnt <= 8'd0;
    end else begin
      if (aw_ready && aw_valid) bid_q <= aw_id;
      if (ar_ready && ar_valid) begin
        rid_q    <= ar_id;
        beat_cnt <= ar_len;
      end else if (r_valid && r_ready && beat_cnt != 8'd0) begin
        beat_cnt <= beat_cnt - 8'd1;
      end
    end
  end

  assign b_id   = bid_q;
  assign r_id   = rid_q;
  assign r_data = '0;

endmodule

// File: rtl/axi_ram_init_gate.sv
// Holds AXI traffic to the DDR2 controller until calibration, then passes through with zero latency;
// on calibration failure/timeout all traffic is answered locally with SLVERR. No transfer is accepted while waiting.
module axi_ram_init_gate
  import swervolf_axi_pkg::*;
#(
  parameter int          ID_WIDTH       = 6,
  parameter int          ADDR_WIDTH     = 27,
  parameter int          DATA_WIDTH     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_init_done,
  input  logic                    i_init_error,
  input  logic [ID_WIDTH-1:0]     s_awid,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [7:0]              s_awlen,
  input  logic [2:0]              s_awsize,
  input  logic [1:0]              s_awburst,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [ID_WIDTH-1:0]     s_bid,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ID_WIDTH-1:0]     s_arid,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [7:0]              s_arlen,
  input  logic [2:0]              s_arsize,
  input  logic [1:0]              s_arburst,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [ID_WIDTH-1:0]     s_rid,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rlast,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [ID_WIDTH-1:0]     m_awid,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wlast,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [ID_WIDTH-1:0]     m_bid,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [ID_WIDTH-1:0]     m_arid,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [ID_WIDTH-1:0]     m_rid,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rlast,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  output logic [1:0]              o_state,
  output logic                    o_timeout
);

  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);

  mode_t       mode_q, mode_d;
  logic        timeout_q, timeout_d;
  logic [31:0] wait_cnt;
  logic        tmo_hit, pass, err;

  assign tmo_hit = (TMO_LIMIT != 32'd0) && (wait_cnt >= TMO_LIMIT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q    <= MODE_WAIT;
      timeout_q <= 1'b0;
      wait_cnt  <= 32'd0;
    end else begin
      mode_q    <= mode_d;
      timeout_q <= timeout_d;
      if (mode_q == MODE_WAIT && wait_cnt != 32'hFFFF_FFFF) wait_cnt <= wait_cnt + 32'd1;
    end
  end

  // Only WAIT has exits; error takes priority over timeout, which takes priority over done
  always_comb begin
    mode_d    = mode_q;
    timeout_d = timeout_q;
    if (mode_q == MODE_WAIT) begin
      if (i_init_error) begin
        mode_d = MODE_ERR;
      end else if (tmo_hit) begin
        mode_d    = MODE_ERR;
        timeout_d = 1'b1;
      end else if (i_init_done) begin
        mode_d = MODE_PASS;
      end
    end
  end

  assign pass      = (mode_q == MODE_PASS);
  assign err       = (mode_q == MODE_ERR);
  assign o_state   = mode_q;
  assign o_timeout = timeout_q;

  logic                  e_awready, e_wready, e_bvalid, e_arready, e_rlast, e_rvalid;
  logic [ID_WIDTH-1:0]   e_bid, e_rid;
  logic [1:0]            e_bresp, e_rresp;
  logic [DATA_WIDTH-1:0] e_rdata;

  axi_err_slave #(
    .ID_WIDTH   (ID_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_err (
    .clk      (clk),
    .rstn     (rstn),
    .en       (err),
    .aw_id    (s_awid),
    .aw_valid (s_awvalid),
    .aw_ready (e_awready),
    .w_last   (s_wlast),
    .w_valid  (s_wvalid),
    .w_ready  (e_wready),
    .b_id     (e_bid),
    .b_resp   (e_bresp),
    .b_valid  (e_bvalid),
    .b_ready  (s_bready),
    .ar_id    (s_arid),
    .ar_len   (s_arlen),
    .ar_valid (s_arvalid),
    .ar_ready (e_arready),
    .r_id     (e_rid),
    .r_data   (e_rdata),
    .r_resp   (e_rresp),
    .r_last   (e_rlast),
    .r_valid  (e_rvalid),
    .r_ready  (s_rready)
  );

  // Payload fields pass through unconditionally; only handshakes are gated by mode
  assign m_awid    = s_awid;
  assign m_awaddr  = s_awaddr;
  assign m_awlen   = s_awlen;
  assign m_awsize  = s_awsize;
  assign m_awburst = s_awburst;
  assign m_awvalid = pass & s_awvalid;
  assign s_awready = (pass & m_awready) | e_awready;

  assign m_wdata   = s_wdata;
  assign m_wstrb   = s_wstrb;
  assign m_wlast   = s_wlast;
  assign m_wvalid  = pass & s_wvalid;
  assign s_wready  = (pass & m_wready) | e_wready;

  assign m_bready  = pass & s_bready;
  assign s_bid     = pass ? m_bid    : e_bid;
  assign s_bresp   = pass ? m_bresp  : e_bresp;
  assign s_bvalid  = pass ? m_bvalid : e_bvalid;

  assign m_arid    = s_arid;
  assign m_araddr  = s_araddr;
  assign m_arlen   = s_arlen;
  assign m_arsize  = s_arsize;
  assign m_arburst = s_arburst;
  assign m_arvalid = pass & s_arvalid;
  assign s_arready = (pass & m_arready) | e_arready;

  assign m_rready  = pass & s_rready;
  assign s_rid     = pass ? m_rid    : e_rid;
  assign s_rdata   = pass ? m_rdata  : e_rdata;
  assign s_rresp   = pass ? m_rresp  : e_rresp;
  assign s_rlast   = pass ? m_rlast  : e_rlast;
  assign s_rvalid  = pass ? m_rvalid : e_rvalid;

endmodule

// File: tb/tb_axi_ram_init_gate.sv
// Directed bench for axi_ram_init_gate: wait/pass/error modes, long error burst, timeout, async reset.
module tb_axi_ram_init_gate;
  localparam int IW = 6;
  localparam int AW = 27;
  localparam int DW = 64;

  logic clk, rstn, rstn2, i_init_done, i_init_error;
  logic [IW-1:0] s_awid, s_arid, m_bid, m_rid;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [7:0] s_awlen, s_arlen;
  logic [2:0] s_awsize, s_arsize;
  logic [1:0] s_awburst, s_arburst, m_bresp, m_rresp;
  logic s_awvalid, s_wlast, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [DW-1:0] s_wdata, m_rdata;
  logic [DW/8-1:0] s_wstrb;
  logic m_awready, m_wready, m_bvalid, m_arready, m_rlast, m_rvalid;

  logic s_awready, s_wready, s_bvalid, s_arready, s_rlast, s_rvalid;
  logic [IW-1:0] s_bid, s_rid, m_awid, m_arid;
  logic [1:0] s_bresp, s_rresp, m_awburst, m_arburst, o_state;
  logic [DW-1:0] s_rdata, m_wdata;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [7:0] m_awlen, m_arlen;
  logic [2:0] m_awsize, m_arsize;
  logic [DW/8-1:0] m_wstrb;
  logic m_awvalid, m_wlast, m_wvalid, m_bready, m_arvalid, m_rready, o_timeout;

  logic t_s_awready, t_s_wready, t_s_bvalid, t_s_arready, t_s_rlast, t_s_rvalid;
  logic [IW-1:0] t_s_bid, t_s_rid, t_m_awid, t_m_arid;
  logic [1:0] t_s_bresp, t_s_rresp, t_m_awburst, t_m_arburst, t_state;
  logic [DW-1:0] t_s_rdata, t_m_wdata;
  logic [AW-1:0] t_m_awaddr, t_m_araddr;
  logic [7:0] t_m_awlen, t_m_arlen;
  logic [2:0] t_m_awsize, t_m_arsize;
  logic [DW/8-1:0] t_m_wstrb;
  logic t_m_awvalid, t_m_wlast, t_m_wvalid, t_m_bready, t_m_arvalid, t_m_rready, t_timeout;

  int vecs = 0;
  int miscompares = 0;

  axi_ram_init_gate #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(0)) dut (
    .clk(clk), .rstn(rstn), .i_init_done(i_init_done), .i_init_error(i_init_error),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .o_state(o_state), .o_timeout(o_timeout)
  );

  axi_ram_init_gate #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(100)) dut_tmo (
    .clk(clk), .rstn(rstn2), .i_init_done(1'b0), .i_init_error(1'b0),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_awvalid(s_awvalid), .s_awready(t_s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(t_s_wready),
    .s_bid(t_s_bid), .s_bresp(t_s_bresp), .s_bvalid(t_s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(t_s_arready),
    .s_rid(t_s_rid), .s_rdata(t_s_rdata), .s_rresp(t_s_rresp), .s_rlast(t_s_rlast), .s_rvalid(t_s_rvalid), .s_rready(s_rready),
    .m_awid(t_m_awid), .m_awaddr(t_m_awaddr), .m_awlen(t_m_awlen), .m_awsize(t_m_awsize), .m_awburst(t_m_awburst),
    .m_awvalid(t_m_awvalid), .m_awready(m_awready),
    .m_wdata(t_m_wdata), .m_wstrb(t_m_wstrb), .m_wlast(t_m_wlast), .m_wvalid(t_m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(t_m_bready),
    .m_arid(t_m_arid), .m_araddr(t_m_araddr), .m_arlen(t_m_arlen), .m_arsize(t_m_arsize), .m_arburst(t_m_arburst),
    .m_arvalid(t_m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(t_m_rready),
    .o_state(t_state), .o_timeout(t_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    int leak, beats, bad;
    rstn = 1'b0; rstn2 = 1'b0; i_init_done = 1'b0; i_init_error = 1'b0;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = 3'd3; s_awburst = 2'b01; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '1; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = 3'd3; s_arburst = 2'b01; s_arvalid = 1'b0; s_rready = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
    m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;

    // Reset values
    step; #1;
    chk("rst_state", o_state, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_ready", {s_awready, s_wready, s_arready, m_bready, m_rready}, 0);
    chk("rst_valid", {s_bvalid, s_rvalid, m_awvalid, m_wvalid, m_arvalid}, 0);
    chk("rst_resp", {s_bresp, s_rresp, s_rlast}, 0);
    step; rstn = 1'b1;

    // WAIT: a pending AR is neither accepted nor forwarded
    s_arvalid = 1'b1; s_arid = 6'h15; s_araddr = 27'h123_4560; s_arlen = 8'd3; m_arready = 1'b1;
    leak = 0;
    for (int i = 0; i < 1000; i++) begin
      step; #1;
      if (s_arready || m_arvalid) leak++;
    end
    chk("wait_no_accept", leak, 0);
    chk("wait_state", o_state, 0);

    // PASS after one-cycle done pulse; 4-beat read passes through with no added latency
    i_init_done = 1'b1;
    step; i_init_done = 1'b0; #1;
    chk("pass_state", o_state, 1);
    chk("pass_arvalid", m_arvalid, 1);
    chk("pass_arid", m_arid, 6'h15);
    chk("pass_araddr", m_araddr, 27'h123_4560);
    chk("pass_arlen", m_arlen, 3);
    chk("pass_arready", s_arready, 1);
    step; s_arvalid = 1'b0; m_arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_rvalid = 1'b1; m_rid = 6'h15; m_rresp = 2'b00; m_rlast = (i == 3);
      m_rdata = 64'hA5A5_0000_0000_0000 + 64'(i); s_rready = 1'b1; #1;
      chk("pass_rvalid", s_rvalid, 1);
      chk("pass_rdata", s_rdata, 64'hA5A5_0000_0000_0000 + 64'(i));
      chk("pass_rid", s_rid, 6'h15);
      chk("pass_rlast", s_rlast, (i == 3));
      chk("pass_rready", m_rready, 1);
      step;
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = 1'b0;

    // Reset, then ERR via init_error
    rstn = 1'b0; #1;
    chk("rst2_state", o_state, 0);
    step; rstn = 1'b1; i_init_error = 1'b1;
    step; #1;
    chk("err_state", o_state, 2);
    chk("err_timeout_clear", o_timeout, 0);

    // ERR write: W before AW is refused, then 8 beats drained, SLVERR B next cycle
    s_wvalid = 1'b1; #1;
    chk("err_w_before_aw", s_wready, 0);
    s_awvalid = 1'b1; s_awid = 6'h2A; s_awlen = 8'd7; s_awaddr = 27'h000_0100; #1;
    chk("err_awready", s_awready, 1);
    chk("err_m_awvalid", m_awvalid, 0);
    step; s_awvalid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_wvalid = 1'b1; s_wlast = (i == 7); s_wdata = 64'hDEAD_0000_0000_0000 + 64'(i); #1;
      chk("err_wready", s_wready, 1);
      chk("err_m_wvalid", m_wvalid, 0);
      step;
    end
    s_wvalid = 1'b0; s_wlast = 1'b0; s_bready = 1'b0; #1;
    chk("err_bvalid", s_bvalid, 1);
    chk("err_bid", s_bid, 6'h2A);
    chk("err_bresp", s_bresp, 2'b10);
    step; #1;
    chk("err_b_hold", {s_bvalid, s_bid, s_bresp}, {1'b1, 6'h2A, 2'b10});
    s_bready = 1'b1;
    step; s_bready = 1'b0; #1;
    chk("err_b_done", s_bvalid, 0);
    i_init_error = 1'b0; i_init_done = 1'b1;
    step; i_init_done = 1'b0; #1;
    chk("err_sticky", o_state, 2);

    // ERR read arlen=255 with rready toggling
    s_arvalid = 1'b1; s_arid = 6'h0B; s_arlen = 8'd255; #1;
    chk("err_arready", s_arready, 1);
    chk("err_m_arvalid", m_arvalid, 0);
    step; s_arvalid = 1'b0; #1;
    chk("err_first_rvalid", s_rvalid, 1);
    beats = 0; bad = 0;
    for (int c = 0; c < 1000 && beats < 256; c++) begin
      s_rready = c[0]; #1;
      if (s_rvalid && s_rready) begin
        beats++;
        if (s_rdata != 64'd0 || s_rresp != 2'b10 || s_rid != 6'h0B || s_rlast != (beats == 256)) bad++;
      end
      step;
    end
    s_rready = 1'b0; #1;
    chk("err_read_beats", beats, 256);
    chk("err_read_fields", bad, 0);
    chk("err_read_done", s_rvalid, 0);

    // Async reset mid ERR burst
    s_arvalid = 1'b1; s_arid = 6'h07; s_arlen = 8'd3; #1;
    chk("err_ar2_ready", s_arready, 1);
    step; s_arvalid = 1'b0; s_rready = 1'b1;
    step; #2; rstn = 1'b0; #1;
    chk("arst_state", o_state, 0);
    chk("arst_rvalid", s_rvalid, 0);
    chk("arst_r_fields", {s_rresp, s_rlast, s_arready}, 0);
    s_rready = 1'b0;
    step; rstn = 1'b1;
    step; #1;
    chk("arst_release_state", o_state, 0);

    // done and error together: error wins
    i_init_done = 1'b1; i_init_error = 1'b1;
    step; i_init_done = 1'b0; i_init_error = 1'b0; #1;
    chk("coincide_state", o_state, 2);
    chk("coincide_timeout", o_timeout, 0);

    // Timeout instance, 100 cycles, no init
    rstn2 = 1'b1;
    repeat (95) step;
    #1;
    chk("tmo_early_state", t_state, 0);
    chk("tmo_early_flag", t_timeout, 0);
    repeat (10) step;
    #1;
    chk("tmo_state", t_state, 2);
    chk("tmo_flag", t_timeout, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
